// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision float utility blocks
// (int-to-float, float-to-int and friends).
package fp_pkg;

  localparam int unsigned FP32_EXP_BIAS    = 127;
  localparam int unsigned FP32_EXP_W       = 8;
  localparam int unsigned FP32_MAN_W       = 23;
  localparam logic [7:0]  FP32_EXP_SPECIAL = 8'hFF;

  // Common sequencing states for the multi-cycle float converters.
  typedef enum logic [1:0] {
    FP_IDLE,
    FP_CAPTURE,
    FP_ALIGN,
    FP_ROUND
  } fp_state_e;

  // Unbiased exponent e-127 as a 9-bit signed value.
  function automatic logic signed [8:0] fp32_unbias(input logic [7:0] e);
    return $signed({1'b0, e}) - $signed(9'(FP32_EXP_BIAS));
  endfunction

endpackage

// File: rtl/floattoint_if.sv
// Start/done handshake and result bus of the float-to-int converter.
interface floattoint_if #(
  parameter int unsigned OUT_WIDTH = 16
) ();

  logic                        start;
  logic [31:0]                 floatin;
  logic signed [OUT_WIDTH-1:0] intout;
  logic                        busy;
  logic                        done;
  logic                        overflow;
  logic                        invalid;

  modport master (
    output start, floatin,
    input  intout, busy, done, overflow, invalid
  );

  modport slave (
    input  start, floatin,
    output intout, busy, done, overflow, invalid
  );

endinterface

// File: rtl/float_align_shift.sv
// Combinational aligner: turns {1,m} and the unbiased exponent into the
// integer part, the first fraction bit (round bit) and a too-large flag.
module float_align_shift
  import fp_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [FP32_MAN_W:0]  man_i,
  input  logic signed [8:0]    exp_i,
  output logic [OUT_WIDTH-1:0] int_o,
  output logic                 round_o,
  output logic                 too_large_o
);

  localparam int unsigned       WIDE_W = FP32_MAN_W + 1 + OUT_WIDTH;
  localparam logic signed [8:0] E_MAX  = 9'(OUT_WIDTH - 1);
  localparam logic signed [8:0] E_MIN  = -9'sd1;

  logic [OUT_WIDTH:0] fix;
  logic [5:0]         shamt;

  // Shifting {1,m} left by E+1 and dropping 23 bits leaves floor(2*|x|):
  // integer part in the upper OUT_WIDTH bits, round bit in bit 0.
  always_comb begin
    fix         = '0;
    shamt       = '0;
    too_large_o = (exp_i >= E_MAX);
    if (!too_large_o && (exp_i >= E_MIN)) begin
      shamt = 6'(exp_i + 9'sd1);
      fix   = (OUT_WIDTH+1)'((WIDE_W'(man_i) << shamt) >> FP32_MAN_W);
    end
    int_o   = fix[OUT_WIDTH:1];
    round_o = fix[0];
  end

endmodule

// File: rtl/floattoint.sv
// Multi-cycle IEEE-754 single to signed integer converter with explicit
// rounding, saturation and NaN flagging.
module floattoint
  import fp_pkg::*;
#(
  parameter int unsigned OUT_WIDTH     = 16,
  parameter bit          ROUND_NEAREST = 1'b1
) (
  input logic         clk,
  input logic         reset,
  floattoint_if.slave bus
);

  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [7:0]           EXP_MIN_EXACT = 8'(FP32_EXP_BIAS + OUT_WIDTH - 1);

  fp_state_e             state_q, state_d;
  logic [31:0]           fin_q, fin_d;
  logic                  sign_q, sign_d;
  logic [7:0]            exp_q, exp_d;
  logic [FP32_MAN_W:0]   man_q, man_d;
  logic [OUT_WIDTH-1:0]  int_q, int_d;
  logic                  rnd_q, rnd_d;
  logic                  big_q, big_d;
  logic [OUT_WIDTH-1:0]  intout_q, intout_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  inv_q, inv_d;

  logic signed [8:0]     exp_unb;
  logic [OUT_WIDTH-1:0]  sh_int;
  logic                  sh_round;
  logic                  sh_big;

  logic [OUT_WIDTH-1:0]  mag;
  logic [OUT_WIDTH-1:0]  sat;
  logic                  man_zero;
  logic [OUT_WIDTH-1:0]  res;
  logic                  res_ovf;
  logic                  res_inv;

  assign exp_unb = fp32_unbias(exp_q);

  float_align_shift #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_align (
    .man_i       (man_q),
    .exp_i       (exp_unb),
    .int_o       (sh_int),
    .round_o     (sh_round),
    .too_large_o (sh_big)
  );

  // Final result: special cases, rounding, saturation and sign.
  always_comb begin
    res      = '0;
    res_ovf  = 1'b0;
    res_inv  = 1'b0;
    man_zero = (man_q[FP32_MAN_W-1:0] == '0);
    sat      = sign_q ? NEG_MIN : POS_MAX;
    mag      = int_q + (ROUND_NEAREST ? OUT_WIDTH'(rnd_q) : '0);
    if (exp_q == '0) begin
      res = '0;
    end else if (exp_q == FP32_EXP_SPECIAL) begin
      if (!man_zero) begin
        res_inv = 1'b1;
      end else begin
        res     = sat;
        res_ovf = 1'b1;
      end
    end else if (big_q) begin
      if (sign_q && (exp_q == EXP_MIN_EXACT) && man_zero) begin
        res = NEG_MIN;
      end else begin
        res     = sat;
        res_ovf = 1'b1;
      end
    end else if (!sign_q && mag[OUT_WIDTH-1]) begin
      res     = POS_MAX;
      res_ovf = 1'b1;
    end else begin
      res = sign_q ? ('0 - mag) : mag;
    end
  end

  // Sequencer: accept, capture fields, align, then round and publish.
  always_comb begin
    state_d  = state_q;
    fin_d    = fin_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    int_d    = int_q;
    rnd_d    = rnd_q;
    big_d    = big_q;
    intout_d = intout_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    case (state_q)
      FP_IDLE: begin
        if (bus.start) begin
          fin_d   = bus.floatin;
          state_d = FP_CAPTURE;
        end
      end
      FP_CAPTURE: begin
        sign_d  = fin_q[31];
        exp_d   = fin_q[FP32_MAN_W +: FP32_EXP_W];
        man_d   = {1'b1, fin_q[FP32_MAN_W-1:0]};
        done_d  = 1'b0;
        state_d = FP_ALIGN;
      end
      FP_ALIGN: begin
        int_d   = sh_int;
        rnd_d   = sh_round;
        big_d   = sh_big;
        state_d = FP_ROUND;
      end
      FP_ROUND: begin
        intout_d = res;
        ovf_d    = res_ovf;
        inv_d    = res_inv;
        done_d   = 1'b1;
        state_d  = FP_IDLE;
      end
      default: state_d = FP_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FP_IDLE;
      fin_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      int_q    <= '0;
      rnd_q    <= 1'b0;
      big_q    <= 1'b0;
      intout_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fin_q    <= fin_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      int_q    <= int_d;
      rnd_q    <= rnd_d;
      big_q    <= big_d;
      intout_q <= intout_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
    end
  end

  assign bus.intout   = intout_q;
  assign bus.busy     = (state_q != FP_IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.invalid  = inv_q;

endmodule

// File: tb/tb_floattoint.sv
// Directed bench for floattoint: one instance per rounding mode, shared
// stimulus, table of hand-computed results plus handshake corner sequences.
module tb_floattoint;

  typedef struct {
    logic [31:0] fin;
    int          rn;
    int          tr;
    bit          ovf_rn;
    bit          ovf_tr;
    bit          inv;
  } vec_t;

  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] floatin;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  vec_t        vecs [NV];
  int          start_cyc [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  floattoint_if #(.OUT_WIDTH(16)) if_rn ();
  floattoint_if #(.OUT_WIDTH(16)) if_tr ();

  assign if_rn.start   = start;
  assign if_rn.floatin = floatin;
  assign if_tr.start   = start;
  assign if_tr.floatin = floatin;

  floattoint #(.OUT_WIDTH(16), .ROUND_NEAREST(1'b1)) dut_rn (
    .clk   (clk),
    .reset (reset),
    .bus   (if_rn)
  );

  floattoint #(.OUT_WIDTH(16), .ROUND_NEAREST(1'b0)) dut_tr (
    .clk   (clk),
    .reset (reset),
    .bus   (if_tr)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic convert(input logic [31:0] x, output int lat, output int busy_cnt,
                         output int scyc);
    start    = 1'b1;
    floatin  = x;
    scyc     = cyc;
    @(negedge clk);
    start    = 1'b0;
    floatin  = ~x;
    lat      = 1;
    busy_cnt = int'(if_rn.busy);
    forever begin
      @(negedge clk);
      lat++;
      if (if_rn.done || lat >= 12) break;
      busy_cnt += int'(if_rn.busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, sc;

    vecs[0]  = '{32'h3F800000,      1,      1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000000,      0,      0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h80000000,      0,      0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h40200000,      3,      2, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hBFC00000,     -2,     -1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h3E800000,      0,      0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h3F000000,      1,      0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'hBF400000,     -1,      0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h46FFFE00,  32767,  32767, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h46FFFF00,  32767,  32767, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h471C4000,  32767,  32767, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{32'hC7000000, -32768, -32768, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'hC7000100, -32768, -32768, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{32'hFF800000, -32768, -32768, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{32'h7F800000,  32767,  32767, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{32'hC6FFFF00, -32768, -32767, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{32'h7FC00000,      0,      0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{32'h3F800000,      1,      1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{32'h00400000,      0,      0, 1'b0, 1'b0, 1'b0};

    reset   = 1'b1;
    start   = 1'b0;
    floatin = '0;
    repeat (3) @(negedge clk);
    check("reset intout",   int'(if_rn.intout),   0);
    check("reset busy",     int'(if_rn.busy),     0);
    check("reset done",     int'(if_rn.done),     0);
    check("reset overflow", int'(if_rn.overflow), 0);
    check("reset invalid",  int'(if_rn.invalid),  0);
    reset = 1'b0;
    @(negedge clk);

    // Table: each start is issued on the negedge where done is seen,
    // so consecutive vectors run back-to-back.
    for (int i = 0; i < NV; i++) begin
      convert(vecs[i].fin, lat, bcnt, sc);
      start_cyc[i] = sc;
      check($sformatf("v%0d latency", i),     lat,  4);
      check($sformatf("v%0d busy_cycles", i), bcnt, 3);
      check($sformatf("v%0d busy_at_done", i), int'(if_rn.busy), 0);
      check($sformatf("v%0d rn intout", i),   int'(if_rn.intout),   vecs[i].rn);
      check($sformatf("v%0d rn overflow", i), int'(if_rn.overflow), int'(vecs[i].ovf_rn));
      check($sformatf("v%0d rn invalid", i),  int'(if_rn.invalid),  int'(vecs[i].inv));
      check($sformatf("v%0d tr intout", i),   int'(if_tr.intout),   vecs[i].tr);
      check($sformatf("v%0d tr overflow", i), int'(if_tr.overflow), int'(vecs[i].ovf_tr));
      check($sformatf("v%0d tr invalid", i),  int'(if_tr.invalid),  int'(vecs[i].inv));
    end
    check("back-to-back period", start_cyc[1] - start_cyc[0], 4);
    check("back-to-back period late", start_cyc[NV-1] - start_cyc[NV-2], 4);

    // start re-pulsed while busy is ignored.
    start   = 1'b1;
    floatin = 32'h3F800000;
    @(negedge clk);
    start   = 1'b0;
    floatin = 32'h0;
    @(negedge clk);
    start   = 1'b1;
    floatin = 32'h471C4000;
    @(negedge clk);
    start   = 1'b0;
    lat     = 3;
    while (!if_rn.done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("ignored start latency",  lat, 4);
    check("ignored start intout",   int'(if_rn.intout),   1);
    check("ignored start overflow", int'(if_rn.overflow), 0);
    repeat (4) @(negedge clk);
    check("ignored start not queued busy", int'(if_rn.busy),   0);
    check("ignored start result held",     int'(if_rn.intout), 1);
    check("done level held",               int'(if_rn.done),   1);

    // Reset mid-conversion: leave flags set first, then abort.
    convert(32'hFF800000, lat, bcnt, sc);
    check("pre-reset intout",   int'(if_rn.intout),   -32768);
    check("pre-reset overflow", int'(if_rn.overflow), 1);
    start   = 1'b1;
    floatin = 32'h40200000;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    check("abort intout",   int'(if_rn.intout),   0);
    check("abort busy",     int'(if_rn.busy),     0);
    check("abort done",     int'(if_rn.done),     0);
    check("abort overflow", int'(if_rn.overflow), 0);
    check("abort invalid",  int'(if_rn.invalid),  0);
    bcnt = 0;
    repeat (6) begin
      @(negedge clk);
      bcnt += int'(if_rn.done) + int'(if_rn.busy);
    end
    check("abort no done", bcnt, 0);

    // Convert after the abort still works.
    convert(32'hBFC00000, lat, bcnt, sc);
    check("post-abort latency", lat, 4);
    check("post-abort rn",      int'(if_rn.intout), -2);
    check("post-abort tr",      int'(if_tr.intout), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floattoint.md
Name: floattoint

Overview:
- Multi-cycle converter from IEEE-754 single precision to a signed two's-complement integer (default 16 bits).
- Reverse direction of the synth's int-to-float path. Turns float DSP results (gains, envelope values, filter outputs) back into 16-bit sample and control words for the DAC and integer datapaths.
- Start/done handshake. Rounding and saturation are explicit and flagged.

Parameters:
- OUT_WIDTH, 16, integer output width; legal range 8..31.
- ROUND_NEAREST, 1, 1 = round to nearest with ties away from zero; 0 = truncate toward zero.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle strobe; captures floatin when idle
- floatin  input  32  IEEE-754 single: sign [31], exponent [30:23], mantissa [22:0]
- intout  output  OUT_WIDTH  signed result; held until the next accepted start
- busy  output  1  high from the accepted start until done rises
- done  output  1  level; high while intout/flags are valid for the last conversion
- overflow  output  1  result was saturated (|value| out of range, including after rounding, or ±inf)
- invalid  output  1  input was NaN (exp=255, mantissa≠0)

Behaviour:
- Reset: intout=0, busy=0, done=0, overflow=0, invalid=0; FSM goes to IDLE. Reset mid-conversion aborts the conversion with no done pulse.
- FSM states:
  - IDLE: start → CAPTURE.
  - CAPTURE: latch s, e, {1,m}; busy=1, done=0.
  - ALIGN → ROUND → IDLE, with done=1 on entering IDLE.
- Latency: start sampled high at edge N; done=1, busy=0 and results valid after edge N+3.
- start while busy=1 is ignored. start with done=1 accepted: done drops at edge N+1.
- Let E = e-127 (signed, 9 bits).
  - e=0 (zero/denormal): result 0, no flags.
  - e=255, mantissa≠0: result 0, invalid=1.
  - e=255, mantissa=0: saturate per sign, overflow=1.
  - E ≥ OUT_WIDTH-1: magnitude ≥ 2^(OUT_WIDTH-1). Saturate, overflow=1, except the exact value -2^(OUT_WIDTH-1) (s=1, E=OUT_WIDTH-1, m=0), which gives the minimum integer with no flag.
  - E ≤ -2: result 0 in both round modes (|x|<0.5).
  - -1 ≤ E ≤ OUT_WIDTH-2: integer part = {1,m} >> (23-E). Round bit = the next bit below the integer part (0 for ROUND_NEAREST=0). Magnitude = int + round, computed OUT_WIDTH bits wide. If the positive magnitude reaches 2^(OUT_WIDTH-1), saturate to max with overflow=1. A negative magnitude of 2^(OUT_WIDTH-1) is legal.
  - Negate the magnitude when s=1.
- Saturation values: +max = 2^(OUT_WIDTH-1)-1; -min = -2^(OUT_WIDTH-1). -0.0 gives 0.
- Flags are updated together with intout and held until the next conversion completes.

Decomposition:
- Shared package `fp_pkg`:
  - FP32_EXP_BIAS=127, FP32_EXP_W=8, FP32_MAN_W=23, FP32_EXP_SPECIAL=8'hFF.
  - The FSM state enum, shared with the int-to-float and other float utility blocks.
- One sub-module, `float_align_shift`: combinational right-shifter taking {1,m} and E. It returns the OUT_WIDTH-bit integer part, the round bit and a "too large" indication. The FSM, rounding, negation and saturation stay in `floattoint`.

Test Plan:
- 0x3F800000 (1.0) → intout=1 at start+3, flags 0; busy high exactly 3 cycles; 0x00000000 and 0x80000000 → 0.
- 0x40200000 (2.5) → 3 with ROUND_NEAREST=1 and 2 with ROUND_NEAREST=0; 0xBFC00000 (-1.5) → -2 / -1; 0x3E800000 (0.25) → 0.
- 0x46FFFE00 (32767.0) → 32767, no flag; 0x46FFFF00 (32767.5, ROUND=1) → 32767, overflow=1; 0x471C4000 (40000.0) → 32767, overflow=1.
- 0xC7000000 (-32768.0) → -32768, overflow=0; 0xC7000100 → -32768, overflow=1; 0xFF800000 (-inf) → -32768, overflow=1.
- 0x7FC00000 (NaN) → 0, invalid=1; the next conversion of 1.0 clears invalid.
- start re-pulsed during busy with a different value → ignored, original result returned. reset asserted at start+2 → all outputs 0, no done. Back-to-back starts at done → one conversion per 4 cycles.
